// File: rtl/tinyv_pkg.sv
// tinyV shared types for the memory arbiter slice.
// Response ownership encoding and memory word geometry.
package tinyv_pkg;

    localparam int MEM_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/tinyv_prio_streak.sv
// Two-requester grant selector: data has priority,
// a saturating streak counter bounds instruction wait.
module tinyv_prio_streak #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    logic [3:0] streak;
    logic       at_limit;

    assign at_limit = (streak >= 4'(MAX_D_STREAK));

    // Pick a winner; nothing is granted while reset is held.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (d_req && !(i_req && at_limit)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Count data wins that happen while a fetch is waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak <= 4'd0;
        end else if (!i_req || i_gnt) begin
            streak <= 4'd0;
        end else if (d_gnt && !at_limit) begin
            streak <= streak + 4'd1;
        end
    end

endmodule

// File: rtl/tinyv_mem_arbiter.sv
// Shares one synchronous-read memory between the fetch
// and data ports; responses return one cycle after grant.
module tinyv_mem_arbiter
    import tinyv_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,
    output logic [31:0]                  i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [31:0]                  d_wdata,
    input  logic [3:0]                   d_wstrb,
    output logic                         d_gnt,
    output logic                         d_rvalid,
    output logic [31:0]                  d_rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_wstrb,
    input  logic [31:0]                  mem_rdata
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int OFS = $clog2(MEM_WORD_BYTES);

    resp_owner_e owner;
    logic        unused_addr_bits;

    // Byte offset and out-of-range upper bits are dropped,
    // so addresses wrap modulo the memory depth.
    assign unused_addr_bits = ^{i_addr[OFS-1:0], d_addr[OFS-1:0],
                                i_addr >> (AW + OFS),
                                d_addr >> (AW + OFS)};

    tinyv_prio_streak #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk  (clk),
        .reset(reset),
        .i_req(i_req),
        .d_req(d_req),
        .i_gnt(i_gnt),
        .d_gnt(d_gnt)
    );

    // Steer the winning request onto the memory port.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[AW+OFS-1:OFS];
            mem_wdata = d_we ? d_wdata : 32'd0;
            mem_wstrb = d_we ? d_wstrb : 4'd0;
        end else if (i_gnt) begin
            mem_en   = 1'b1;
            mem_addr = i_addr[AW+OFS-1:OFS];
        end
    end

    // Remember who owns the data coming back next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner <= OWN_NONE;
        end else if (d_gnt) begin
            owner <= OWN_D;
        end else if (i_gnt) begin
            owner <= OWN_I;
        end else begin
            owner <= OWN_NONE;
        end
    end

    // Route the memory response to its owner only.
    always_comb begin
        i_rvalid = (owner == OWN_I);
        d_rvalid = (owner == OWN_D);
        i_rdata  = i_rvalid ? mem_rdata : 32'd0;
        d_rdata  = d_rvalid ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_tinyv_mem_arbiter.sv
// Randomized and directed bench for tinyv_mem_arbiter
// against a behavioural word-memory and grant model.
module tb_tinyv_mem_arbiter;

    localparam int MAX = 4;
    localparam int MW  = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    tinyv_mem_arbiter #(
        .ADDR_W(32), .MEM_WORDS(MW), .MAX_D_STREAK(MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 2) return 32'h0020_81B3;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    // Device memory: synchronous read, byte-strobed write.
    logic        init_done = 1'b0;
    logic [31:0] mem [0:MW-1];
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < MW; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b])
                        mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    logic [31:0] ref_mem [0:MW-1];
    int          d_run;
    logic        i_pend, d_pend, i_hold, d_hold;
    logic [31:0] i_a, d_a, d_wd;
    logic        d_w;
    logic [3:0]  d_ws;
    logic        obs_ig;

    task automatic step();
        logic ei, ed, xw;
        int idx;
        logic [31:0] xd;
        i_req = i_pend; i_addr = i_a;
        d_req = d_pend; d_we = d_w; d_addr = d_a;
        d_wdata = d_wd; d_wstrb = d_ws;
        #2;
        ei = 1'b0; ed = 1'b0;
        if (reset) begin
            if (i_pend && d_pend) begin
                if (d_run >= MAX) ei = 1'b1; else ed = 1'b1;
            end else begin
                ei = i_pend; ed = d_pend;
            end
        end
        obs_ig = i_gnt;
        check("i_gnt", i_gnt, ei);
        check("d_gnt", d_gnt, ed);
        check("mem_en", mem_en, ei | ed);
        idx = ed ? int'((d_a >> 2) % MW) : ei ? int'((i_a >> 2) % MW) : 0;
        xw = ed && d_w;
        check("mem_we", mem_we, xw);
        check("mem_addr", mem_addr, idx);
        check("mem_wstrb", mem_wstrb, xw ? d_ws : 4'd0);
        if (xw) check("mem_wdata", mem_wdata, d_wd);
        xd = ref_mem[idx];
        if (xw)
            for (int b = 0; b < 4; b++)
                if (d_ws[b]) ref_mem[idx][8*b +: 8] = d_wd[8*b +: 8];
        if (!reset || !i_pend || ei) d_run = 0;
        else if (ed) d_run++;
        @(posedge clk); #1;
        check("i_rvalid", i_rvalid, ei);
        check("d_rvalid", d_rvalid, ed);
        if (ei) check("i_rdata", i_rdata, xd);
        if (ed && !xw) check("d_rdata", d_rdata, xd);
        if (!reset) begin
            check("i_rdata_rst", i_rdata, 32'd0);
            check("d_rdata_rst", d_rdata, 32'd0);
        end
        if (ei && !i_hold) i_pend = 1'b0;
        if (ed && !d_hold) d_pend = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_F003;
        if ($urandom_range(0, 1) == 0) a = a & 32'h0000_0003;
        return a | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        reset = 1'b0;
        i_pend = 1'b1; d_pend = 1'b1; i_hold = 1'b0; d_hold = 1'b0;
        i_a = 32'h8; d_a = 32'h0; d_w = 1'b0; d_wd = '0; d_ws = '0;
        d_run = 0;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
        @(posedge clk); #1;
        init_done = 1'b1;
        // Reset held with both requests high
        step();
        step();
        check("rst_i_rvalid", i_rvalid, 1'b0);
        check("rst_d_rvalid", d_rvalid, 1'b0);
        reset = 1'b1;
        i_pend = 1'b0; d_pend = 1'b0;

        // Fetch of word 2 in the first cycle after release
        i_pend = 1'b1; i_a = 32'h8;
        step();
        check("fetch_word2", i_rdata, 32'h0020_81B3);

        // Byte write then read-back of word 0
        d_pend = 1'b1; d_w = 1'b1; d_a = 32'h0; d_wd = 32'h45; d_ws = 4'b0001;
        step();
        d_pend = 1'b1; d_w = 1'b0;
        step();
        check("byte_write", d_rdata, {init_val(0) [31:8], 8'h45});

        // Alternating I, D, I
        i_pend = 1'b1; i_a = 32'h10; step();
        d_pend = 1'b1; d_w = 1'b0; d_a = 32'h14; step();
        i_pend = 1'b1; i_a = 32'h18; step();

        // Wrap-around address
        d_pend = 1'b1; d_w = 1'b0; d_a = 32'h1004;
        #2;
        d_req = 1'b1; d_addr = d_a; d_we = 1'b0;
        #1;
        check("wrap_addr", mem_addr, 10'd1);
        step();

        // Streak pattern D,D,D,D,I with both held high
        step();
        i_pend = 1'b1; d_pend = 1'b1; i_hold = 1'b1; d_hold = 1'b1;
        i_a = 32'h20; d_a = 32'h24; d_w = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check("streak_pattern", obs_ig, (k % 5) == 4);
        end
        i_hold = 1'b0; d_hold = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0;
        step();

        // Reset while a data read response is due
        d_pend = 1'b1; d_w = 1'b0; d_a = 32'h30;
        step();
        d_pend = 1'b1; i_pend = 1'b1;
        d_a = 32'h34; i_a = 32'h38;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        i_pend = 1'b0; d_pend = 1'b0;
        step();
        check("post_rst_d_rvalid", d_rvalid, 1'b0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if (!i_pend && $urandom_range(0, 99) < 60) begin
                i_pend = 1'b1; i_a = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 99) < 65) begin
                d_pend = 1'b1; d_a = rand_addr();
                d_w = $urandom_range(0, 1) == 1;
                d_wd = $urandom; d_ws = 4'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
